// File: rtl/sd_cmd_ctrl_if.sv
// Host-side command/response bus of the SD command-path sequencer.
// The register layer is the master; sd_cmd_ctrl is the slave.
interface sd_cmd_ctrl_if;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic [134:0] resp_out;
  logic         done;
  logic         timeout;
  logic         busy;

  modport master (
    output cmd_valid, cmd_index, cmd_arg, resp_type,
    input  cmd_ready, resp_out, done, timeout, busy
  );

  modport slave (
    input  cmd_valid, cmd_index, cmd_arg, resp_type,
    output cmd_ready, resp_out, done, timeout, busy
  );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// SD command-path sequencer: shifts a 48-bit command frame out on CMD, then
// runs the response receiver under NCR and receive watchdogs and reports the
// captured response with a completion/timeout status.
module sd_cmd_ctrl #(
  parameter int NCR_MAX    = 64,
  parameter int GAP_CYCLES = 2,
  parameter int RX_MAX     = 160
) (
  input  logic           clk,
  input  logic           reset,
  sd_cmd_ctrl_if.slave   host,
  output logic           sd_cmd_out,
  output logic           sd_cmd_oe,
  output logic           rx_en,
  output logic           rx_r2,
  input  logic           rx_started,
  input  logic           rx_finished,
  input  logic [134:0]   rx_response
);

  // One counter serves every timed state; size it for the longest of them.
  localparam int CNT_TOP  = (RX_MAX > NCR_MAX) ? RX_MAX : NCR_MAX;
  localparam int CNT_W    = $clog2(((CNT_TOP > 48) ? CNT_TOP : 48) + 1);
  localparam int FRAME_W  = 48;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TX        = 3'd1,
    GAP       = 3'd2,
    WAIT_RESP = 3'd3,
    RECV      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [FRAME_W-1:0]   frame_reg;
  logic                 none_reg;     // request expects no response
  logic                 r2_reg;       // request expects a 136-bit response
  logic                 timeout_reg;
  logic [134:0]         resp_reg;

  logic                 accept;
  logic                 tx_last;
  logic                 gap_last;
  logic                 ncr_last;
  logic                 rx_last;
  logic [39:0]          prefix;

  // CRC7 (x^7 + x^3 + 1, init 0) over the 40 prefix bits, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = c[6] ^ bits[i];
      c  = {c[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    end
    return c;
  endfunction

  assign accept   = (state_reg == IDLE) && host.cmd_valid;
  assign prefix   = {2'b01, host.cmd_index, host.cmd_arg};
  assign tx_last  = (cnt_reg == CNT_W'(FRAME_W - 1));
  assign gap_last = (cnt_reg == CNT_W'(GAP_CYCLES - 1));
  assign ncr_last = (cnt_reg == CNT_W'(NCR_MAX - 1));
  assign rx_last  = (cnt_reg == CNT_W'(RX_MAX - 1));

  // State register; reset aborts any command and releases CMD at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic; start/finish flags win over the final watchdog count.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (host.cmd_valid) state_next = TX;
      TX:        if (tx_last) state_next = none_reg ? DONE : GAP;
      GAP:       if (gap_last) state_next = WAIT_RESP;
      WAIT_RESP: begin
        if (rx_started)    state_next = RECV;
        else if (ncr_last) state_next = DONE;
      end
      RECV:      if (rx_finished || rx_last) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Shared cycle counter: restarts on every state change, runs in timed states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (state_next != state_reg) begin
      cnt_reg <= '0;
    end else if (state_reg != IDLE && state_reg != DONE) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Request capture and frame shifter; the CRC is folded in at accept time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_reg <= '0;
      none_reg  <= 1'b0;
      r2_reg    <= 1'b0;
    end else if (accept) begin
      frame_reg <= {prefix, crc7(prefix), 1'b1};
      none_reg  <= (host.resp_type == 2'b00);
      r2_reg    <= (host.resp_type == 2'b10);
    end else if (state_reg == TX) begin
      frame_reg <= {frame_reg[FRAME_W-2:0], 1'b1};
    end
  end

  // Completion status: cleared by a new accept, set when a watchdog expires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_reg <= 1'b0;
    end else if (accept) begin
      timeout_reg <= 1'b0;
    end else if (state_reg == WAIT_RESP && !rx_started && ncr_last) begin
      timeout_reg <= 1'b1;
    end else if (state_reg == RECV && !rx_finished && rx_last) begin
      timeout_reg <= 1'b1;
    end
  end

  // Response capture; only a completed receive replaces the held response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_reg <= '0;
    end else if (state_reg == RECV && rx_finished) begin
      resp_reg <= rx_response;
    end
  end

  // Output decode from the current state and the held registers.
  always_comb begin
    host.cmd_ready = (state_reg == IDLE);
    host.busy      = (state_reg != IDLE);
    host.done      = (state_reg == DONE);
    host.timeout   = timeout_reg;
    host.resp_out  = resp_reg;
    sd_cmd_oe      = (state_reg == TX);
    sd_cmd_out     = (state_reg == TX) ? frame_reg[FRAME_W-1] : 1'b1;
    rx_en          = (state_reg == WAIT_RESP) || (state_reg == RECV);
    rx_r2          = rx_en && r2_reg;
  end

endmodule
